pipe_ctrl: RTL and testbench

Pipelined successor to the single-cycle MIPS control decoder. It decodes the ID-stage instruction and registers the control bundle into the ID/EX boundary. It also detects load-use hazards, handles taken-branch flush from EX, latches and prioritises `NUM_IRQ` edge-triggered interrupt sources, and drives the fetch PC-select, stall and flush lines. It sits between the IF/ID register and the EX stage of the 5-stage core.

---
 rtl/pipe_ctrl_if.sv | 57 +++++
 rtl/pipe_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: ID-stage control bus between the IF/ID register, the EX
// stage and the pipe_ctrl decoder.
//   slave  modport : pipe_ctrl side (decodes ID, drives fetch control and
//                    the registered ID/EX control bundle)
//   master modport : core / testbench side
// Signals:
//   id_valid, id_instr[31:0], id_kernel  - instruction currently in ID
//   irq[NUM_IRQ]                         - edge-triggered interrupt lines
//   ex_branch_taken                      - branch compare result in EX
//   pc_src[2:0], stall, flush_if         - fetch control
//   irq_ack[NUM_IRQ], irq_id[IRQ_IDW]    - interrupt take indication
//   ex_*                                 - registered ID/EX control bundle
interface pipe_ctrl_if #(
  parameter int NUM_IRQ = 4,
  parameter int IRQ_IDW = 2
);
  logic               id_valid;
  logic [31:0]        id_instr;
  logic               id_kernel;
  logic [NUM_IRQ-1:0] irq;
  logic               ex_branch_taken;
  logic [2:0]         pc_src;
  logic               stall;
  logic               flush_if;
  logic [NUM_IRQ-1:0] irq_ack;
  logic [IRQ_IDW-1:0] irq_id;
  logic               ex_valid;
  logic [2:0]         ex_pcsrc;
  logic [1:0]         ex_regdst;
  logic               ex_regwr;
  logic               ex_alusrc1;
  logic               ex_alusrc2;
  logic [5:0]         ex_alufun;
  logic               ex_sign;
  logic               ex_memwr;
  logic               ex_memrd;
  logic [1:0]         ex_memtoreg;
  logic               ex_extop;
  logic               ex_luop;
  logic [4:0]         ex_rt;

  modport slave (
    input  id_valid, id_instr, id_kernel, irq, ex_branch_taken,
    output pc_src, stall, flush_if, irq_ack, irq_id,
           ex_valid, ex_pcsrc, ex_regdst, ex_regwr, ex_alusrc1, ex_alusrc2,
           ex_alufun, ex_sign, ex_memwr, ex_memrd, ex_memtoreg, ex_extop,
           ex_luop, ex_rt
  );

  modport master (
    output id_valid, id_instr, id_kernel, irq, ex_branch_taken,
    input  pc_src, stall, flush_if, irq_ack, irq_id,
           ex_valid, ex_pcsrc, ex_regdst, ex_regwr, ex_alusrc1, ex_alusrc2,
           ex_alufun, ex_sign, ex_memwr, ex_memrd, ex_memtoreg, ex_extop,
           ex_luop, ex_rt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipelined MIPS control unit for the 5-stage core.
// Decodes the ID instruction into a control bundle registered at the ID/EX
// boundary, detects load-use hazards, applies taken-branch flushes from EX,
// latches and prioritises edge-triggered interrupts (index 0 highest), and
// drives the fetch PC select / stall / IF flush lines.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - pipe_ctrl_if.slave (ID inputs, irq lines, fetch control,
//           interrupt ack, registered ex_* bundle)
module pipe_ctrl #(
  parameter int NUM_IRQ = 4,
  parameter int IRQ_IDW = 2
) (
  input  logic           clk,
  input  logic           reset,
  pipe_ctrl_if.slave     bus
);

  localparam logic [2:0] PC_SEQ = 3'd0;
  localparam logic [2:0] PC_BR  = 3'd1;
  localparam logic [2:0] PC_J   = 3'd2;
  localparam logic [2:0] PC_JR  = 3'd3;
  localparam logic [2:0] PC_IRQ = 3'd4;
  localparam logic [2:0] PC_EXC = 3'd5;

  typedef struct packed {
    logic       valid;
    logic [2:0] pcsrc;
    logic [1:0] regdst;
    logic       regwr;
    logic       alusrc1;
    logic       alusrc2;
    logic [5:0] alufun;
    logic       sign;
    logic       memwr;
    logic       memrd;
    logic [1:0] memtoreg;
    logic       extop;
    logic       luop;
    logic [4:0] rt;
  } ctl_t;

  function automatic logic is_defined(input logic [31:0] instr);
    logic [5:0] op;
    logic [5:0] fn;
    op = instr[31:26];
    fn = instr[5:0];
    if (op == 6'h00)
      is_defined = fn inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
                              [6'h20:6'h27], 6'h2a};
    else
      is_defined = op inside {[6'h01:6'h0d], 6'h0f, 6'h23, 6'h2b};
  endfunction

  function automatic ctl_t decode(input logic [31:0] instr);
    logic [5:0] op;
    logic [5:0] fn;
    ctl_t       d;
    op = instr[31:26];
    fn = instr[5:0];
    d          = '0;
    d.valid    = 1'b1;
    d.rt       = instr[20:16];
    d.regdst   = 2'd1;
    d.regwr    = 1'b1;
    d.alusrc2  = 1'b1;
    d.sign     = 1'b1;
    d.extop    = 1'b1;
    if (op == 6'h00) begin
      d.regdst  = 2'd0;
      d.alusrc2 = 1'b0;
      case (fn)
        6'h00: begin d.alufun = 6'b100000; d.alusrc1 = 1'b1; end
        6'h02: begin d.alufun = 6'b100001; d.alusrc1 = 1'b1; end
        6'h03: begin d.alufun = 6'b100011; d.alusrc1 = 1'b1; end
        6'h08: begin d.alufun = 6'b100000; d.pcsrc = PC_JR; d.regwr = 1'b0; end
        6'h09: begin d.alufun = 6'b100000; d.pcsrc = PC_JR; d.memtoreg = 2'd2; end
        6'h20: d.alufun = 6'b000000;
        6'h21: begin d.alufun = 6'b000000; d.sign = 1'b0; end
        6'h22: d.alufun = 6'b000001;
        6'h23: begin d.alufun = 6'b000001; d.sign = 1'b0; end
        6'h24: d.alufun = 6'b011000;
        6'h25: d.alufun = 6'b011110;
        6'h26: d.alufun = 6'b010110;
        6'h27: d.alufun = 6'b010001;
        6'h2a: d.alufun = 6'b110101;
        default: ;
      endcase
    end else begin
      case (op)
        6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin
          d.pcsrc   = PC_BR;
          d.regwr   = 1'b0;
          d.alusrc2 = 1'b0;
          case (op)
            6'h01:   d.alufun = 6'b111011;
            6'h04:   d.alufun = 6'b110011;
            6'h05:   d.alufun = 6'b110001;
            6'h06:   d.alufun = 6'b111101;
            default: d.alufun = 6'b111111;
          endcase
        end
        6'h02: begin d.alufun = 6'b100000; d.pcsrc = PC_J; d.regwr = 1'b0; end
        6'h03: begin
          d.alufun   = 6'b100000;
          d.pcsrc    = PC_J;
          d.regdst   = 2'd2;
          d.memtoreg = 2'd2;
        end
        6'h08: d.alufun = 6'b000000;
        6'h09: begin d.alufun = 6'b000000; d.sign = 1'b0; end
        6'h0a: d.alufun = 6'b110101;
        6'h0b: begin d.alufun = 6'b110101; d.sign = 1'b0; end
        6'h0c: begin d.alufun = 6'b011000; d.extop = 1'b0; end
        6'h0d: begin d.alufun = 6'b011110; d.extop = 1'b0; end
        6'h0f: begin d.alufun = 6'b000000; d.luop = 1'b1; end
        6'h23: begin d.alufun = 6'b000000; d.memrd = 1'b1; d.memtoreg = 2'd1; end
        6'h2b: begin d.alufun = 6'b000000; d.memwr = 1'b1; d.regwr = 1'b0; end
        default: ;
      endcase
    end
    decode = d;
  endfunction

  // Interrupt / exception pseudo-instruction: jumps to the vector and
  // writes the return address to register 3-select via the link path.
  function automatic ctl_t trap_bundle(input logic [2:0] code);
    ctl_t t;
    t          = '0;
    t.valid    = 1'b1;
    t.pcsrc    = code;
    t.regdst   = 2'd3;
    t.regwr    = 1'b1;
    t.memtoreg = 2'd2;
    trap_bundle = t;
  endfunction

  ctl_t               idex_p1;
  ctl_t               nxt_p0;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] sel_oh;
  logic [IRQ_IDW-1:0] sel_id;
  logic               found;
  logic               flush;
  logic               hazard;
  logic               stall_c;
  logic               take;
  logic               redirect;

  // ---- ID stage (p0): hazard, flush and interrupt selection ----
  assign flush  = idex_p1.valid && (idex_p1.pcsrc == PC_BR) && bus.ex_branch_taken;
  assign hazard = idex_p1.valid && idex_p1.memrd && (idex_p1.rt != 5'd0) &&
                  ((idex_p1.rt == bus.id_instr[25:21]) ||
                   (idex_p1.rt == bus.id_instr[20:16])) && bus.id_valid;
  assign stall_c = hazard && !flush;
  assign take    = (|pend) && bus.id_valid && !bus.id_kernel && !stall_c && !flush;

  always_comb begin
    sel_oh = '0;
    sel_id = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pend[i] && !found) begin
        found     = 1'b1;
        sel_oh[i] = 1'b1;
        sel_id    = IRQ_IDW'(i);
      end
    end
  end

  always_comb begin
    nxt_p0 = '0;
    if (!flush && !stall_c && bus.id_valid) begin
      if (take)
        nxt_p0 = trap_bundle(PC_IRQ);
      else if (is_defined(bus.id_instr))
        nxt_p0 = decode(bus.id_instr);
      else if (!bus.id_kernel)
        nxt_p0 = trap_bundle(PC_EXC);
    end
  end

  // Jumps, irq and exception redirect fetch from ID; branches wait for EX.
  assign redirect     = (nxt_p0.pcsrc >= PC_J);
  assign bus.pc_src   = flush ? PC_BR : (redirect ? nxt_p0.pcsrc : PC_SEQ);
  assign bus.flush_if = flush || redirect;
  assign bus.stall    = stall_c;
  assign bus.irq_ack  = take ? sel_oh : '0;
  assign bus.irq_id   = take ? sel_id : '0;

  // ---- ID/EX boundary (p1) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_p1  <= '0;
      pend     <= '0;
      irq_prev <= '1;
    end else begin
      idex_p1  <= nxt_p0;
      // A new edge wins over the clear from this cycle's ack.
      pend     <= (bus.irq & ~irq_prev) | (pend & ~bus.irq_ack);
      irq_prev <= bus.irq;
    end
  end

  assign bus.ex_valid    = idex_p1.valid;
  assign bus.ex_pcsrc    = idex_p1.pcsrc;
  assign bus.ex_regdst   = idex_p1.regdst;
  assign bus.ex_regwr    = idex_p1.regwr;
  assign bus.ex_alusrc1  = idex_p1.alusrc1;
  assign bus.ex_alusrc2  = idex_p1.alusrc2;
  assign bus.ex_alufun   = idex_p1.alufun;
  assign bus.ex_sign     = idex_p1.sign;
  assign bus.ex_memwr    = idex_p1.memwr;
  assign bus.ex_memrd    = idex_p1.memrd;
  assign bus.ex_memtoreg = idex_p1.memtoreg;
  assign bus.ex_extop    = idex_p1.extop;
  assign bus.ex_luop     = idex_p1.luop;
  assign bus.ex_rt       = idex_p1.rt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed testbench for pipe_ctrl. Drives cycle-by-cycle
// instruction / irq / branch vectors and compares fetch-control and ID/EX
// bundle outputs against hand-computed values.
module tb_pipe_ctrl;

  localparam logic [31:0] I_ADD     = 32'h012A4020; // add $8,$9,$10
  localparam logic [31:0] I_LW      = 32'h8D280000; // lw $8,0($9)
  localparam logic [31:0] I_ADD_DEP = 32'h010C5820; // add $11,$8,$12
  localparam logic [31:0] I_BEQ     = 32'h10220004; // beq $1,$2,4
  localparam logic [31:0] I_UNDEF   = 32'hFC000000; // opcode 0x3F
  localparam logic [31:0] I_JR      = 32'h03E00008; // jr $31
  localparam logic [31:0] I_JAL     = 32'h0C000010; // jal 0x40
  localparam logic [31:0] I_SRA     = 32'h00031103; // sra $2,$3,4
  localparam logic [31:0] I_ANDI    = 32'h308200FF; // andi $2,$4,0xff
  localparam logic [31:0] I_ADDIU   = 32'h24020001; // addiu $2,$0,1

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  pipe_ctrl_if #(.NUM_IRQ(4), .IRQ_IDW(2)) bus ();

  pipe_ctrl #(.NUM_IRQ(4), .IRQ_IDW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.id_valid = 1'b0;
    bus.id_instr = 32'h0;
    bus.id_kernel = 1'b0;
    bus.irq = 4'b0001;
    bus.ex_branch_taken = 1'b0;
    tick; tick;
    check("rst_ex_valid", bus.ex_valid, 0);
    check("rst_ex_alufun", bus.ex_alufun, 0);
    check("rst_pc_src", bus.pc_src, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_flush_if", bus.flush_if, 0);
    check("rst_irq_ack", bus.irq_ack, 0);

    // irq[0] held high through reset release must not look like an edge
    reset = 1'b0;
    bus.id_valid = 1'b1;
    bus.id_instr = I_ADD;
    #1;
    check("irq_held_no_ack", bus.irq_ack, 0);
    check("add_pc_src", bus.pc_src, 0);
    tick;
    check("add_ex_valid", bus.ex_valid, 1);
    check("add_ex_alufun", bus.ex_alufun, 6'b000000);
    check("add_ex_regdst", bus.ex_regdst, 0);
    check("add_ex_regwr", bus.ex_regwr, 1);
    check("add_ex_alusrc2", bus.ex_alusrc2, 0);
    check("add_ex_rt", bus.ex_rt, 10);
    check("irq_held_no_ack2", bus.irq_ack, 0);

    // load-use
    bus.id_instr = I_LW;
    tick;
    check("lw_ex_memrd", bus.ex_memrd, 1);
    check("lw_ex_memtoreg", bus.ex_memtoreg, 1);
    check("lw_ex_rt", bus.ex_rt, 8);
    bus.id_instr = I_ADD_DEP;
    #1;
    check("lu_stall", bus.stall, 1);
    check("lu_flush_if", bus.flush_if, 0);
    tick;
    check("lu_bubble_valid", bus.ex_valid, 0);
    check("lu_stall_released", bus.stall, 0);
    tick;
    check("lu_issue_valid", bus.ex_valid, 1);
    check("lu_issue_rt", bus.ex_rt, 12);

    // taken branch in EX flushes ID
    bus.id_instr = I_BEQ;
    tick;
    check("beq_ex_pcsrc", bus.ex_pcsrc, 1);
    check("beq_ex_alufun", bus.ex_alufun, 6'b110011);
    check("beq_ex_regwr", bus.ex_regwr, 0);
    bus.ex_branch_taken = 1'b1;
    bus.id_instr = I_LW;
    #1;
    check("br_pc_src", bus.pc_src, 1);
    check("br_flush_if", bus.flush_if, 1);
    check("br_stall", bus.stall, 0);
    tick;
    check("br_bubble_valid", bus.ex_valid, 0);

    // interrupts 0000 -> 0110
    bus.ex_branch_taken = 1'b0;
    bus.irq = 4'b0000;
    bus.id_instr = I_ADD;
    #1;
    check("pre_irq_pc_src", bus.pc_src, 0);
    tick;
    bus.irq = 4'b0110;
    #1;
    check("irq_latency", bus.irq_ack, 0);
    tick;
    check("irq1_ack", bus.irq_ack, 4'b0010);
    check("irq1_id", bus.irq_id, 1);
    check("irq1_pc_src", bus.pc_src, 4);
    check("irq1_flush_if", bus.flush_if, 1);
    tick;
    check("irq_ex_regdst", bus.ex_regdst, 3);
    check("irq_ex_pcsrc", bus.ex_pcsrc, 4);
    check("irq_ex_memtoreg", bus.ex_memtoreg, 2);
    check("irq2_ack", bus.irq_ack, 4'b0100);
    check("irq2_id", bus.irq_id, 2);
    tick;
    check("irq_cleared", bus.irq_ack, 0);

    // undefined opcode: user exception, kernel bubble
    bus.id_instr = I_UNDEF;
    #1;
    check("exc_pc_src", bus.pc_src, 5);
    check("exc_flush_if", bus.flush_if, 1);
    tick;
    check("exc_ex_memtoreg", bus.ex_memtoreg, 2);
    check("exc_ex_pcsrc", bus.ex_pcsrc, 5);
    bus.id_kernel = 1'b1;
    #1;
    check("kexc_pc_src", bus.pc_src, 0);
    check("kexc_flush_if", bus.flush_if, 0);
    tick;
    check("kexc_ex_valid", bus.ex_valid, 0);
    check("kexc_ex_memtoreg", bus.ex_memtoreg, 0);

    // jumps and assorted decodes
    bus.id_kernel = 1'b0;
    bus.id_instr = I_JR;
    #1;
    check("jr_pc_src", bus.pc_src, 3);
    tick;
    check("jr_ex_pcsrc", bus.ex_pcsrc, 3);
    check("jr_ex_regwr", bus.ex_regwr, 0);
    bus.id_instr = I_JAL;
    #1;
    check("jal_pc_src", bus.pc_src, 2);
    tick;
    check("jal_ex_regdst", bus.ex_regdst, 2);
    check("jal_ex_memtoreg", bus.ex_memtoreg, 2);
    bus.id_instr = I_SRA;
    tick;
    check("sra_ex_alusrc1", bus.ex_alusrc1, 1);
    check("sra_ex_alufun", bus.ex_alufun, 6'b100011);
    bus.id_instr = I_ANDI;
    tick;
    check("andi_ex_extop", bus.ex_extop, 0);
    check("andi_ex_alufun", bus.ex_alufun, 6'b011000);
    check("andi_ex_alusrc2", bus.ex_alusrc2, 1);
    bus.id_instr = I_ADDIU;
    tick;
    check("addiu_ex_sign", bus.ex_sign, 0);
    check("addiu_ex_regdst", bus.ex_regdst, 1);

    // reset during a stall, with a fresh irq[0] edge in the same cycle
    bus.id_instr = I_LW;
    tick;
    check("lw2_ex_memrd", bus.ex_memrd, 1);
    bus.id_instr = I_ADD_DEP;
    bus.irq = 4'b0111;
    #1;
    check("lu2_stall", bus.stall, 1);
    reset = 1'b1;
    tick;
    check("rst_stall_ex_valid", bus.ex_valid, 0);
    check("rst_stall_ex_memrd", bus.ex_memrd, 0);
    check("rst_stall_stall", bus.stall, 0);
    reset = 1'b0;
    #1;
    check("rst_stall_irq_ack", bus.irq_ack, 0);
    tick;
    check("rst_pend_lost", bus.irq_ack, 0);
    check("post_rst_ex_valid", bus.ex_valid, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
